audio_dc_ramp: RTL and testbench

//  Audio conditioning stage between the core's SOUND_L/SOUND_R outputs and the 2nd-order PWM/sigma-delta DAC.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_hp_chan.sv | 41 ++++
 rtl/audio_dc_ramp.sv | 100 ++++++++++
 tb/tb_audio_dc_ramp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/accumulator types, FSM states and 16-bit saturation for audio_dc_ramp
// Contents: sample_t (16-bit signed), acc_t (26-bit signed), state_t, SAMPLE_MAX/SAMPLE_MIN, sat16()
package audio_pkg;
  typedef logic signed [15:0] sample_t;
  typedef logic signed [25:0] acc_t;
  typedef enum logic [2:0] {IDLE, LATCH, CALC_L, CALC_R, OUT} state_t;
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;
  function automatic sample_t sat16(acc_t a);
    return a > acc_t'(SAMPLE_MAX) ? SAMPLE_MAX : a < acc_t'(SAMPLE_MIN) ? SAMPLE_MIN : a[15:0];
  endfunction
endpackage

// File: rtl/audio_hp_chan.sv
// audio_hp_chan: one channel of the DC-blocking high-pass, state advances when en_i is high
// Ports: clk_i clock, rst_i async active-high reset, en_i update strobe,
//        x_i signed input sample, y_o signed filtered sample (integer part).
// With AUDIO_DCBLOCK_EN undefined the channel is a wire (y_o = x_i) and holds no state.
module audio_hp_chan
  import audio_pkg::*;
#(
  parameter int HP_SHIFT = 10
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  sample_t x_i,
  output sample_t y_o
);
`ifdef AUDIO_DCBLOCK_EN
  localparam acc_t Y_MAX = acc_t'(8388607);
  localparam acc_t Y_MIN = acc_t'(-8388608);
  sample_t xp_q;
  logic signed [23:0] yp_q, y_d;
  acc_t y_full;
  // y_prev carries 8 fractional bits; a full-scale step can exceed the 24-bit store, so clamp it
  always_comb begin
    y_full = (acc_t'(x_i) <<< 8) - (acc_t'(xp_q) <<< 8) + acc_t'(yp_q) - (acc_t'(yp_q) >>> HP_SHIFT);
    y_d = y_full > Y_MAX ? 24'sh7FFFFF : y_full < Y_MIN ? 24'sh800000 : y_full[23:0];
  end
  assign y_o = y_d[23:8];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      xp_q <= '0;
      yp_q <= '0;
    end else if (en_i) begin
      xp_q <= x_i;
      yp_q <= y_d;
    end
`else
  logic unused;
  assign unused = ^{clk_i, rst_i, en_i};
  assign y_o = x_i;
`endif
endmodule

// File: rtl/audio_dc_ramp.sv
// audio_dc_ramp: DC-blocking high-pass plus click-free soft-start/soft-mute gain ramp for the stereo DAC path
// Ports: clk_sys clock, reset async active-high, ce 28 MHz enable, mute fade request,
//        in_l/in_r signed core samples, out_l/out_r signed conditioned samples,
//        sample_stb one-cycle update pulse, ramp_done gain at full scale, silent gain at zero.
// Optional feature: AUDIO_DCBLOCK_EN enables the high-pass; undefined gives y = x with identical timing.
module audio_dc_ramp
  import audio_pkg::*;
#(
  parameter int CE_DIV    = 583,
  parameter int GAIN_BITS = 10,
  parameter int HP_SHIFT  = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce,
  input  logic               mute,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               sample_stb,
  output logic               ramp_done,
  output logic               silent
);
  localparam int CW = $clog2(CE_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE = CW'(1);
  localparam logic [GAIN_BITS:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0] GAIN_ONE = {{GAIN_BITS{1'b0}}, 1'b1};
  logic [CW-1:0] div_q;
  logic tick_q, mute_q;
  logic [GAIN_BITS:0] gain_q, gain_d;
  state_t state_q;
  sample_t lat_l_q, lat_r_q, pl_q, y_l, y_r, y_sel, p;
  acc_t prod;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= ce && div_q == DIV_LAST;
      if (ce) div_q <= div_q == DIV_LAST ? '0 : div_q + DIV_ONE;
    end
  audio_hp_chan #(.HP_SHIFT(HP_SHIFT)) u_hp_l (
    .clk_i(clk_sys), .rst_i(reset), .en_i(state_q == CALC_L), .x_i(lat_l_q), .y_o(y_l)
  );
  audio_hp_chan #(.HP_SHIFT(HP_SHIFT)) u_hp_r (
    .clk_i(clk_sys), .rst_i(reset), .en_i(state_q == CALC_R), .x_i(lat_r_q), .y_o(y_r)
  );
  // One multiplier serves both channels: left in CALC_L, right in CALC_R
  always_comb begin
    gain_d = mute_q ? (gain_q != '0 ? gain_q - GAIN_ONE : gain_q)
                    : (gain_q != GAIN_FULL ? gain_q + GAIN_ONE : gain_q);
    y_sel  = state_q == CALC_L ? y_l : y_r;
    prod   = acc_t'(y_sel) * acc_t'($signed({1'b0, gain_q}));
    p      = sat16(prod >>> GAIN_BITS);
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      lat_l_q    <= '0;
      lat_r_q    <= '0;
      mute_q     <= 1'b0;
      pl_q       <= '0;
      gain_q     <= '0;
      out_l      <= '0;
      out_r      <= '0;
      sample_stb <= 1'b0;
      ramp_done  <= 1'b0;
      silent     <= 1'b1;
    end else begin
      sample_stb <= 1'b0;
      case (state_q)
        IDLE: if (tick_q) begin
          state_q <= LATCH;
          lat_l_q <= in_l;
          lat_r_q <= in_r;
          mute_q  <= mute;
        end
        LATCH: state_q <= CALC_L;
        CALC_L: begin
          pl_q    <= p;
          state_q <= CALC_R;
        end
        CALC_R: begin
          out_l      <= pl_q;
          out_r      <= p;
          gain_q     <= gain_d;
          ramp_done  <= gain_d == GAIN_FULL;
          silent     <= gain_d == '0;
          sample_stb <= 1'b1;
          state_q    <= OUT;
        end
        OUT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // CE_DIV >= 8 guarantees the pipeline has drained before the next tick
  tick_idle_a: assert property (@(posedge clk_sys) disable iff (reset) tick_q |-> state_q == IDLE);
endmodule

// File: tb/tb_audio_dc_ramp.sv
// tb_audio_dc_ramp: self-checking bench for audio_dc_ramp (model-checked strobes plus directed corner sequences)
module tb_audio_dc_ramp;
  localparam int CE_DIV = 8;
  typedef struct {
    logic signed [15:0] il;
    logic signed [15:0] ir;
    logic signed [15:0] el;
    logic signed [15:0] er;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, mute = 1'b0;
  logic signed [15:0] in_l = '0, in_r = '0;
  logic signed [15:0] out_l, out_r;
  logic sample_stb, ramp_done, silent;
  int checks = 0, errors = 0, stb_cnt = 0, wraps = 0;
  bit ce_rand = 1'b0, ce_hold = 1'b0;
  longint cyc = 0, wrap_cyc = 0, ce_n = 0;
  longint m_gain = 0, el = 0, er = 0;
  longint xp[2], yp[2];
  vec_t vecs[6];

  audio_dc_ramp #(.CE_DIV(CE_DIV)) dut (
    .clk_sys(clk), .reset(reset), .ce(ce), .mute(mute), .in_l(in_l), .in_r(in_r),
    .out_l(out_l), .out_r(out_r), .sample_stb(sample_stb), .ramp_done(ramp_done), .silent(silent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  // Reference channel: DC-blocking recurrence in plain integer arithmetic (8 fractional bits)
  function automatic longint chan(input int c, input longint x);
`ifdef AUDIO_DCBLOCK_EN
    longint y;
    y = clamp(256 * x - 256 * xp[c] + yp[c] - (yp[c] >>> 10), -(longint'(1) << 23), (longint'(1) << 23) - 1);
    xp[c] = x;
    yp[c] = y;
    return y >>> 8;
`else
    return x + 0 * c;
`endif
  endfunction

  function automatic longint gained(input longint yi);
    return clamp((yi * m_gain) >>> 10, -32768, 32767);
  endfunction

  // prescaler reference: every CE_DIV-th ce pulse since reset is a wrap
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) ce_n = 0;
    else if (ce) begin
      ce_n++;
      if (ce_n % CE_DIV == 0) begin
        wrap_cyc = cyc;
        wraps++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    ce = ce_hold ? 1'b0 : ce_rand ? ($urandom_range(3) != 0) : 1'b1;
  end

  // scoreboard: inputs only change right after a strobe, so the values seen now are the ones captured
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_gain = 0;
      xp = '{0, 0};
      yp = '{0, 0};
    end else if (sample_stb) begin
      stb_cnt++;
      el = gained(chan(0, longint'(in_l)));
      er = gained(chan(1, longint'(in_r)));
      m_gain = mute ? (m_gain > 0 ? m_gain - 1 : 0) : (m_gain < 1024 ? m_gain + 1 : 1024);
      chk("out_l", out_l, el);
      chk("out_r", out_r, er);
      chk("ramp_done", ramp_done, longint'(m_gain == 1024));
      chk("silent", silent, longint'(m_gain == 0));
      chk("latency", cyc - wrap_cyc, 4);
    end
  end

  task automatic wait_stb(input int n);
    int got = 0, t = 0;
    while (got < n && t < n * CE_DIV * 8 + 100) begin
      @(negedge clk);
      t++;
      if (sample_stb && !reset) got++;
    end
    if (got < n) chk("stb_timeout", got, n);
    #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w, t, s;
    vecs[0] = '{16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh8000};
    vecs[1] = '{16'sh0001, -16'sh0001, 16'sh0001, -16'sh0001};
    vecs[2] = '{16'sh4000, 16'shC000, 16'sh4000, 16'shC000};
    vecs[3] = '{16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000};
    vecs[4] = '{16'sh1234, -16'sh1234, 16'sh1234, -16'sh1234};
    vecs[5] = '{16'sh8000, 16'sh7FFF, 16'sh8000, 16'sh7FFF};
    in_l = 16'sh4000;
    in_r = 16'sh4000;
    repeat (3) @(negedge clk);
    chk("rst_out_l", out_l, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_ramp_done", ramp_done, 0);
    chk("rst_silent", silent, 1);
    #1 reset = 1'b0;
    n = 0;
    do begin
      wait_stb(1);
      n++;
    end while (!ramp_done && n < 1100);
    chk("fadein_ticks", n, 1024);
`ifdef AUDIO_DCBLOCK_EN
    wait_stb(5000 - 1024);
    chk("dc_decay_l", longint'(out_l < 256 && out_l > -256), 1);
    chk("dc_decay_r", longint'(out_r < 256 && out_r > -256), 1);
`else
    for (int i = 0; i < 6; i++) begin
      in_l = vecs[i].il;
      in_r = vecs[i].ir;
      wait_stb(1);
      chk($sformatf("vec%0d_l", i), out_l, vecs[i].el);
      chk($sformatf("vec%0d_r", i), out_r, vecs[i].er);
    end
`endif
    in_l = 16'sh4000;
    in_r = 16'sh4000;
    wait_stb(1);
    mute = 1'b1;
    n = 0;
    do begin
      wait_stb(1);
      n++;
    end while (!silent && n < 1100);
    chk("mute_ticks", n, 1024);
    mute = 1'b0;
    wait_stb(600);
    chk("rise600_not_done", ramp_done, 0);
    mute = 1'b1;
    wait_stb(100);
    mute = 1'b0;
    wait_stb(1);
`ifndef AUDIO_DCBLOCK_EN
    chk("rev_at500", out_l, 8000);
`endif
    wait_stb(1);
`ifndef AUDIO_DCBLOCK_EN
    chk("rev_at501", out_l, 8016);
`endif
    mute = 1'b1;
    wait_stb(202);
    mute = 1'b0;
    w = wraps;
    t = 0;
    while (wraps == w && t < CE_DIV * 8) begin
      @(negedge clk);
      t++;
    end
    if (wraps == w) chk("wrap_timeout", wraps, w + 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_l", out_l, 0);
    chk("midrst_out_r", out_r, 0);
    chk("midrst_stb", sample_stb, 0);
    chk("midrst_ramp_done", ramp_done, 0);
    chk("midrst_silent", silent, 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    wait_stb(1);
    chk("restart_out", out_l, 0);
    chk("restart_silent", silent, 0);
    wait_stb(1);
`ifndef AUDIO_DCBLOCK_EN
    chk("restart_gain1", out_l, 16);
`endif
    ce_rand = 1'b1;
    repeat (400) begin
      in_l = $urandom_range(7) == 0 ? 16'sh8000 : $urandom_range(7) == 0 ? 16'sh7FFF : 16'($urandom);
      in_r = 16'($urandom);
      if ($urandom_range(30) == 0) mute = ~mute;
      wait_stb(1);
    end
    ce_rand = 1'b0;
    wait_stb(1);
    s = stb_cnt;
    ce_hold = 1'b1;
    repeat (200) @(negedge clk);
    chk("hold_no_stb", stb_cnt - s, 0);
    chk("hold_out_l", out_l, el);
    chk("hold_out_r", out_r, er);
    ce_hold = 1'b0;
    wait_stb(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
